// File: rtl/bp_be_pkg.sv
// Shared types for the backend late-writeback path: the entry layout carried
// through the per-source buffers and the round-robin pointer encoding.

`define BP_BE_DECLARE_LATE_WB_ENTRY_S(data_width_mp, reg_addr_width_mp) \
    typedef struct packed {                                             \
        logic                         float;                            \
        logic [reg_addr_width_mp-1:0] rd_addr;                          \
        logic [data_width_mp-1:0]     data;                             \
    } bp_be_late_wb_entry_s

`define BP_BE_LATE_WB_ENTRY_WIDTH(data_width_mp, reg_addr_width_mp) \
    (1 + (reg_addr_width_mp) + (data_width_mp))

package bp_be_pkg;

    localparam int unsigned bp_be_num_src_lp  = 2;
    localparam int unsigned bp_be_num_port_lp = 2;

    // Source indices into the per-source arrays
    localparam int unsigned bp_be_src_mem_lp  = 0;
    localparam int unsigned bp_be_src_long_lp = 1;

    typedef enum logic {
        e_rr_mem  = 1'b0,
        e_rr_long = 1'b1
    } bp_be_rr_e;

    // Only a contended fire moves the pointer, and it moves toward the loser.
    function automatic bp_be_rr_e bp_be_rr_next(
        input bp_be_rr_e rr,
        input logic      fire,
        input logic      contended,
        input logic      mem_won
    );
        if (fire && contended) begin
            return mem_won ? e_rr_long : e_rr_mem;
        end
        return rr;
    endfunction

endpackage

// File: rtl/bp_be_late_wb_fifo.sv
// In-order 1r1w buffer for one late-writeback source. The head is read
// straight from storage, so an entry written at an edge is visible next cycle.

module bp_be_late_wb_fifo
    import bp_be_pkg::*;
#(
    parameter int unsigned width_p = 70,
    parameter int unsigned els_p   = 2,
    localparam int unsigned ptr_width_lp = $clog2(els_p),
    localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    v_i,
    input  logic [width_p-1:0]      data_i,
    input  logic                    yumi_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
    logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [width_p-1:0]      mem_q [els_p];

    // Depth is a power of two, so pointer increments wrap on their own.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (v_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (yumi_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({v_i, yumi_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (v_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == cnt_width_lp'(els_p));
    assign v_o     = ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(v_i && full_o));
            assert (!(yumi_i && empty_o));
        end
    end

endmodule

// File: rtl/bp_be_late_wb_arb.sv
// Late-writeback collector: buffers the memory pipe and the long-latency pipe
// separately and steers each head to the integer or FP regfile late port.

module bp_be_late_wb_arb
    import bp_be_pkg::*;
#(
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned reg_addr_width_p = 5,
    parameter int unsigned fifo_els_p       = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        mem_v_i,
    input  logic                        mem_float_i,
    input  logic [reg_addr_width_p-1:0] mem_rd_addr_i,
    input  logic [data_width_p-1:0]     mem_data_i,
    output logic                        mem_yumi_o,

    input  logic                        long_v_i,
    input  logic                        long_float_i,
    input  logic [reg_addr_width_p-1:0] long_rd_addr_i,
    input  logic [data_width_p-1:0]     long_data_i,
    output logic                        long_ready_o,

    output logic                        iwb_v_o,
    output logic [reg_addr_width_p-1:0] iwb_rd_addr_o,
    output logic [data_width_p-1:0]     iwb_data_o,
    input  logic                        iwb_ready_i,

    output logic                        fwb_v_o,
    output logic [reg_addr_width_p-1:0] fwb_rd_addr_o,
    output logic [data_width_p-1:0]     fwb_data_o,
    input  logic                        fwb_ready_i,

    output logic                        empty_o
);

    `BP_BE_DECLARE_LATE_WB_ENTRY_S(data_width_p, reg_addr_width_p);

    localparam int unsigned entry_width_lp = `BP_BE_LATE_WB_ENTRY_WIDTH(data_width_p, reg_addr_width_p);
    localparam int unsigned cnt_width_lp   = $clog2(fifo_els_p + 1);

    // Per-source arrays: index 0 = memory pipe, 1 = long-latency pipe
    logic [bp_be_num_src_lp-1:0]                   enq, deq, head_v, full, fifo_empty;
    logic [bp_be_num_src_lp-1:0][cnt_width_lp-1:0] count;
    bp_be_late_wb_entry_s [bp_be_num_src_lp-1:0]   wr_entry, head_entry;

    // Per-port arrays: index 0 = integer, 1 = FP; inner index is the source
    logic [bp_be_num_port_lp-1:0][bp_be_num_src_lp-1:0] cand, grant;
    logic [bp_be_num_port_lp-1:0]                       port_v, port_ready, fire;
    bp_be_late_wb_entry_s [bp_be_num_port_lp-1:0]       port_entry;
    bp_be_rr_e                                          rr_q [bp_be_num_port_lp];
    bp_be_rr_e                                          rr_d [bp_be_num_port_lp];

    assign mem_yumi_o   = mem_v_i & ~full[bp_be_src_mem_lp] & reset_n_i;
    assign long_ready_o = ~full[bp_be_src_long_lp] & reset_n_i;

    assign enq[bp_be_src_mem_lp]  = mem_yumi_o;
    assign enq[bp_be_src_long_lp] = long_v_i & long_ready_o;

    assign wr_entry[bp_be_src_mem_lp] = '{
        float:   mem_float_i,
        rd_addr: mem_rd_addr_i,
        data:    mem_data_i
    };
    assign wr_entry[bp_be_src_long_lp] = '{
        float:   long_float_i,
        rd_addr: long_rd_addr_i,
        data:    long_data_i
    };

    genvar gi;
    generate
        for (gi = 0; gi < bp_be_num_src_lp; gi++) begin : g_src
            bp_be_late_wb_fifo #(
                .width_p (entry_width_lp),
                .els_p   (fifo_els_p)
            ) u_fifo (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .v_i       (enq[gi]),
                .data_i    (wr_entry[gi]),
                .yumi_i    (deq[gi]),
                .v_o       (head_v[gi]),
                .data_o    (head_entry[gi]),
                .full_o    (full[gi]),
                .empty_o   (fifo_empty[gi]),
                .count_o   (count[gi])
            );

            // A head leaves only through the port its float flag selects.
            assign deq[gi] = (fire[0] & grant[0][gi]) | (fire[1] & grant[1][gi]);

            always @(posedge clk_i) begin
                if (reset_n_i) begin
                    assert (count[gi] <= cnt_width_lp'(fifo_els_p));
                end
            end
        end

        for (gi = 0; gi < bp_be_num_port_lp; gi++) begin : g_port
            localparam logic port_is_fp_lp = (gi == 1);

            assign cand[gi][0] = head_v[0] & (head_entry[0].float == port_is_fp_lp);
            assign cand[gi][1] = head_v[1] & (head_entry[1].float == port_is_fp_lp);

            assign grant[gi][0] = cand[gi][0] & (~cand[gi][1] | (rr_q[gi] == e_rr_mem));
            assign grant[gi][1] = cand[gi][1] & (~cand[gi][0] | (rr_q[gi] == e_rr_long));

            assign port_v[gi]     = |cand[gi];
            assign fire[gi]       = port_v[gi] & port_ready[gi];
            assign port_entry[gi] = grant[gi][0] ? head_entry[0]
                                  : grant[gi][1] ? head_entry[1]
                                  : '0;

            always @(posedge clk_i) begin
                if (reset_n_i) begin
                    assert (!(grant[gi][0] && grant[gi][1]));
                end
            end
        end
    endgenerate

    assign port_ready = {fwb_ready_i, iwb_ready_i};

    always_comb begin
        for (int p = 0; p < bp_be_num_port_lp; p++) begin
            rr_d[p] = bp_be_rr_next(rr_q[p], fire[p], &cand[p], grant[p][0]);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int p = 0; p < bp_be_num_port_lp; p++) begin
                rr_q[p] <= e_rr_mem;
            end
        end else begin
            for (int p = 0; p < bp_be_num_port_lp; p++) begin
                rr_q[p] <= rr_d[p];
            end
        end
    end

    assign iwb_v_o       = port_v[0];
    assign iwb_rd_addr_o = port_entry[0].rd_addr;
    assign iwb_data_o    = port_entry[0].data;

    assign fwb_v_o       = port_v[1];
    assign fwb_rd_addr_o = port_entry[1].rd_addr;
    assign fwb_data_o    = port_entry[1].data;

    assign empty_o = &fifo_empty;

endmodule
